// File: rtl/spi_shift_engine.sv
// spi_shift_engine
//   SPI character engine driven by the rising/falling SCK strobes of an
//   upstream clock generator. It latches a transmit character and shifts it
//   out on mosi_o. It samples miso_i into a right-aligned receive shifter,
//   using the edge roles selected by CPOL/CPHA. It returns the received
//   character together with a single-cycle done_o pulse.
//
// Ports
//   sysclk, rst_n    system clock, asynchronous active-low reset
//   enable_i         low aborts any transfer and holds the engine idle
//   start_i          start a character (accepted while busy_o = 0)
//   cpol_i, cpha_i   SPI mode; lsb_first_i selects bit order
//   char_len_i       character length in bits, 0 means MAX_LEN
//   tx_data_i        transmit character, right-aligned
//   pos_edge_i       rising-SCK strobe from the clock generator
//   neg_edge_i       falling-SCK strobe from the clock generator
//   miso_i           serial input, already synchronous to sysclk
//   go_o             run request to the clock generator
//   last_clk_o       final SCK period indicator to the clock generator
//   mosi_o           serial output
//   busy_o           transfer in progress
//   done_o           one-cycle end-of-character pulse
//   rx_data_o        received character, right-aligned, upper bits zero
//
// State table
//   state | meaning
//   IDLE  | waiting for start_i; go/busy/mosi low
//   XFER  | character in flight; strobes shift and sample
//   DONE  | one cycle; done_o high, rx_data_o freshly valid

module spi_shift_engine #(
    parameter int MAX_LEN = 32,
    parameter int LEN_W   = $clog2(MAX_LEN)
) (
    input  logic               sysclk,
    input  logic               rst_n,
    input  logic               enable_i,
    input  logic               start_i,
    input  logic               cpol_i,
    input  logic               cpha_i,
    input  logic               lsb_first_i,
    input  logic [LEN_W-1:0]   char_len_i,
    input  logic [MAX_LEN-1:0] tx_data_i,
    input  logic               pos_edge_i,
    input  logic               neg_edge_i,
    input  logic               miso_i,
    output logic               go_o,
    output logic               last_clk_o,
    output logic               mosi_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [MAX_LEN-1:0] rx_data_o
);

    localparam int CNT_W = LEN_W + 1;

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t             state_q;
    logic               xfer_q;
    logic               done_q;
    logic               last_clk_q;
    logic               mosi_q;
    logic               cpol_q;
    logic               cpha_q;
    logic               lsb_q;
    logic [CNT_W-1:0]   len_q;
    logic [MAX_LEN-1:0] tx_q;
    logic [MAX_LEN-1:0] rx_sh_q;
    logic [MAX_LEN-1:0] rx_sh_d;
    logic [MAX_LEN-1:0] rx_data_q;
    logic [CNT_W-1:0]   lead_cnt_q;
    logic [CNT_W-1:0]   trail_cnt_q;

    logic               lead_stb;
    logic               trail_stb;
    logic               lead_fire;
    logic               trail_fire;
    logic               samp_fire;
    logic [CNT_W-1:0]   samp_cnt;
    logic [CNT_W-1:0]   len_in;
    logic [CNT_W-1:0]   lead_nxt;
    logic [CNT_W-1:0]   trail_nxt;

    // Position of the k-th transferred bit within the right-aligned character.
    function automatic logic [LEN_W-1:0] bit_idx(input logic [CNT_W-1:0] k,
                                                 input logic [CNT_W-1:0] len,
                                                 input logic             lsb);
        return LEN_W'(lsb ? k : (len - k - 1'b1));
    endfunction

    assign len_in    = (char_len_i == '0) ? CNT_W'(MAX_LEN) : {1'b0, char_len_i};
    assign lead_nxt  = lead_cnt_q + 1'b1;
    assign trail_nxt = trail_cnt_q + 1'b1;

    // A coincident pair of strobes is treated as a leading edge only.
    assign lead_stb   = cpol_q ? neg_edge_i : pos_edge_i;
    assign trail_stb  = (cpol_q ? pos_edge_i : neg_edge_i) & ~lead_stb;
    assign lead_fire  = (state_q == XFER) && lead_stb  && (lead_cnt_q  < len_q);
    assign trail_fire = (state_q == XFER) && trail_stb && (trail_cnt_q < len_q);

    always_comb begin
        rx_sh_d   = rx_sh_q;
        samp_cnt  = cpha_q ? trail_cnt_q : lead_cnt_q;
        samp_fire = cpha_q ? trail_fire : lead_fire;
        if (samp_fire) begin
            rx_sh_d[bit_idx(samp_cnt, len_q, lsb_q)] = miso_i;
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            xfer_q      <= 1'b0;
            done_q      <= 1'b0;
            last_clk_q  <= 1'b0;
            mosi_q      <= 1'b0;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            lsb_q       <= 1'b0;
            len_q       <= '0;
            tx_q        <= '0;
            rx_sh_q     <= '0;
            rx_data_q   <= '0;
            lead_cnt_q  <= '0;
            trail_cnt_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (!enable_i) begin
                state_q    <= IDLE;
                xfer_q     <= 1'b0;
                last_clk_q <= 1'b0;
                mosi_q     <= 1'b0;
            end else begin
                case (state_q)
                    XFER: begin
                        rx_sh_q <= rx_sh_d;
                        if (lead_fire) begin
                            lead_cnt_q <= lead_nxt;
                            if (lead_nxt == len_q) last_clk_q <= 1'b1;
                            if (cpha_q) mosi_q <= tx_q[bit_idx(lead_cnt_q, len_q, lsb_q)];
                        end else if (trail_fire) begin
                            trail_cnt_q <= trail_nxt;
                            if (trail_nxt == len_q) begin
                                // The final sample (cpha=1) is folded in via rx_sh_d.
                                state_q    <= DONE;
                                xfer_q     <= 1'b0;
                                done_q     <= 1'b1;
                                last_clk_q <= 1'b0;
                                mosi_q     <= 1'b0;
                                rx_data_q  <= rx_sh_d;
                            end else if (!cpha_q) begin
                                mosi_q <= tx_q[bit_idx(trail_nxt, len_q, lsb_q)];
                            end
                        end
                    end
                    default: begin
                        state_q    <= IDLE;
                        xfer_q     <= 1'b0;
                        last_clk_q <= 1'b0;
                        mosi_q     <= 1'b0;
                        if (start_i) begin
                            state_q     <= XFER;
                            xfer_q      <= 1'b1;
                            cpol_q      <= cpol_i;
                            cpha_q      <= cpha_i;
                            lsb_q       <= lsb_first_i;
                            len_q       <= len_in;
                            tx_q        <= tx_data_i;
                            rx_sh_q     <= '0;
                            lead_cnt_q  <= '0;
                            trail_cnt_q <= '0;
                            mosi_q      <= cpha_i ? 1'b0
                                                  : tx_data_i[bit_idx('0, len_in, lsb_first_i)];
                        end
                    end
                endcase
            end
        end
    end

    assign go_o       = xfer_q;
    assign busy_o     = xfer_q;
    assign done_o     = done_q;
    assign last_clk_o = last_clk_q;
    assign mosi_o     = mosi_q;
    assign rx_data_o  = rx_data_q;

endmodule

// File: tb/tb_spi_shift_engine.sv
module tb_spi_shift_engine;

    logic        sysclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable_i = 1'b1;
    logic        start_i = 1'b0;
    logic        cpol_i = 1'b0;
    logic        cpha_i = 1'b0;
    logic        lsb_first_i = 1'b0;
    logic [4:0]  char_len_i = '0;
    logic [31:0] tx_data_i = '0;
    logic        pos_edge_i = 1'b0;
    logic        neg_edge_i = 1'b0;
    logic        miso_i = 1'b0;
    logic        go_o, last_clk_o, mosi_o, busy_o, done_o;
    logic [31:0] rx_data_o;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    logic m_cpol, m_cpha, m_lsb;

    spi_shift_engine dut (
        .sysclk(sysclk), .rst_n(rst_n), .enable_i(enable_i), .start_i(start_i),
        .cpol_i(cpol_i), .cpha_i(cpha_i), .lsb_first_i(lsb_first_i),
        .char_len_i(char_len_i), .tx_data_i(tx_data_i),
        .pos_edge_i(pos_edge_i), .neg_edge_i(neg_edge_i), .miso_i(miso_i),
        .go_o(go_o), .last_clk_o(last_clk_o), .mosi_o(mosi_o), .busy_o(busy_o),
        .done_o(done_o), .rx_data_o(rx_data_o)
    );

    always #5 sysclk = ~sysclk;

    always @(posedge sysclk) if (done_o === 1'b1) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input bit leading);
        if (leading ^ m_cpol) pos_edge_i = 1'b1;
        else                  neg_edge_i = 1'b1;
        @(negedge sysclk);
        pos_edge_i = 1'b0;
        neg_edge_i = 1'b0;
    endtask

    // Called at a negedge; leaves the bench at the negedge where busy/go must be valid.
    task automatic start_char(input bit cpol, input bit cpha, input bit lsb,
                              input logic [4:0] clen, input logic [31:0] tx,
                              input bit exp_first);
        cpol_i = cpol; cpha_i = cpha; lsb_first_i = lsb;
        char_len_i = clen; tx_data_i = tx;
        m_cpol = cpol; m_cpha = cpha; m_lsb = lsb;
        start_i = 1'b1;
        @(negedge sysclk);
        start_i = 1'b0;
        chk("start_busy", {31'd0, busy_o}, 32'd1);
        chk("start_go", {31'd0, go_o}, 32'd1);
        chk("start_mosi", {31'd0, mosi_o}, {31'd0, exp_first});
    endtask

    // Runs len SCK periods; returns at the negedge where DONE must be visible.
    task automatic run_bits(input int len, input bit loop, input logic [31:0] pat,
                            input logic [31:0] exp_rx, input logic [31:0] exp_cap,
                            input string tag);
        logic [31:0] cap;
        int idx;
        cap = '0;
        for (int i = 0; i < len; i++) begin
            idx = m_lsb ? i : len - 1 - i;
            @(negedge sysclk);
            if (!m_cpha) begin
                miso_i = loop ? mosi_o : pat[i];
                cap[idx] = mosi_o;
            end
            strobe(1'b1);
            if (i == len - 1) chk({tag, "_lastclk_set"}, {31'd0, last_clk_o}, 32'd1);
            if (i == len - 2) chk({tag, "_lastclk_early"}, {31'd0, last_clk_o}, 32'd0);
            @(negedge sysclk);
            if (m_cpha) begin
                miso_i = loop ? mosi_o : pat[i];
                cap[idx] = mosi_o;
            end
            if (i == len - 1) chk({tag, "_lastclk_hold"}, {31'd0, last_clk_o}, 32'd1);
            strobe(1'b0);
        end
        chk({tag, "_done"}, {31'd0, done_o}, 32'd1);
        chk({tag, "_done_go"}, {31'd0, go_o}, 32'd0);
        chk({tag, "_done_busy"}, {31'd0, busy_o}, 32'd0);
        chk({tag, "_done_lastclk"}, {31'd0, last_clk_o}, 32'd0);
        chk({tag, "_done_mosi"}, {31'd0, mosi_o}, 32'd0);
        chk({tag, "_rx"}, rx_data_o, exp_rx);
        chk({tag, "_mosi_seq"}, cap, exp_cap);
    endtask

    initial begin
        m_cpol = 1'b0; m_cpha = 1'b0; m_lsb = 1'b0;
        #12;
        chk("rst_go", {31'd0, go_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_mosi", {31'd0, mosi_o}, 32'd0);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        chk("rst_lastclk", {31'd0, last_clk_o}, 32'd0);
        chk("rst_rx", rx_data_o, 32'd0);
        @(negedge sysclk);
        rst_n = 1'b1;
        @(negedge sysclk);
        @(negedge sysclk);

        // Mode 0, MSB-first, 8 bits, loopback.
        start_char(1'b0, 1'b0, 1'b0, 5'd8, 32'h0000_00A5, 1'b1);
        run_bits(8, 1'b1, 32'h0, 32'h0000_00A5, 32'h0000_00A5, "m0");
        chk("m0_done_cnt", done_cnt, 32'd0);

        // start in DONE: next character, and a start/config change while busy is ignored.
        start_char(1'b0, 1'b0, 1'b0, 5'd8, 32'h0000_003C, 1'b0);
        chk("b2b_done_clear", {31'd0, done_o}, 32'd0);
        chk("b2b_done_cnt", done_cnt, 32'd1);
        start_i = 1'b1; tx_data_i = 32'hFFFF_FFFF; char_len_i = 5'd4;
        cpha_i = 1'b1; cpol_i = 1'b1; lsb_first_i = 1'b1;
        @(negedge sysclk);
        start_i = 1'b0;
        chk("busy_start_busy", {31'd0, busy_o}, 32'd1);
        run_bits(8, 1'b1, 32'h0, 32'h0000_003C, 32'h0000_003C, "b2b");
        @(negedge sysclk);
        chk("idle_done", {31'd0, done_o}, 32'd0);
        chk("idle_busy", {31'd0, busy_o}, 32'd0);
        chk("idle_mosi", {31'd0, mosi_o}, 32'd0);
        chk("idle_done_cnt", done_cnt, 32'd2);

        // Mode 3, LSB-first, 4 bits, miso 1,1,0,1.
        start_char(1'b1, 1'b1, 1'b1, 5'd4, 32'h0000_0006, 1'b0);
        run_bits(4, 1'b0, 32'h0000_000B, 32'h0000_000B, 32'h0000_0006, "m3");
        @(negedge sysclk);

        // Mode 1, char_len 0 -> 32 bits, MSB-first, loopback.
        start_char(1'b0, 1'b1, 1'b0, 5'd0, 32'h8000_0001, 1'b0);
        run_bits(32, 1'b1, 32'h0, 32'h8000_0001, 32'h8000_0001, "m1");
        @(negedge sysclk);
        chk("m1_done_cnt", done_cnt, 32'd4);

        // Abort after the third leading strobe.
        start_char(1'b0, 1'b0, 1'b0, 5'd8, 32'h0000_00F0, 1'b1);
        strobe(1'b1); strobe(1'b0);
        strobe(1'b1); strobe(1'b0);
        strobe(1'b1);
        enable_i = 1'b0;
        @(negedge sysclk);
        chk("abort_go", {31'd0, go_o}, 32'd0);
        chk("abort_busy", {31'd0, busy_o}, 32'd0);
        chk("abort_mosi", {31'd0, mosi_o}, 32'd0);
        chk("abort_lastclk", {31'd0, last_clk_o}, 32'd0);
        strobe(1'b0);
        @(negedge sysclk);
        chk("abort_no_done", done_cnt, 32'd4);
        chk("abort_rx_hold", rx_data_o, 32'h8000_0001);
        enable_i = 1'b1;
        @(negedge sysclk);
        start_char(1'b0, 1'b0, 1'b0, 5'd8, 32'h0000_005A, 1'b0);
        run_bits(8, 1'b1, 32'h0, 32'h0000_005A, 32'h0000_005A, "after_abort");
        @(negedge sysclk);
        chk("after_abort_cnt", done_cnt, 32'd5);

        // Reset mid-transfer.
        start_char(1'b0, 1'b0, 1'b0, 5'd8, 32'h0000_00C3, 1'b1);
        strobe(1'b1); strobe(1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_go", {31'd0, go_o}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy_o}, 32'd0);
        chk("mid_rst_mosi", {31'd0, mosi_o}, 32'd0);
        chk("mid_rst_done", {31'd0, done_o}, 32'd0);
        chk("mid_rst_rx", rx_data_o, 32'd0);
        @(negedge sysclk);
        rst_n = 1'b1;
        @(negedge sysclk);
        @(negedge sysclk);
        chk("mid_rst_cnt", done_cnt, 32'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
